// File: rtl/rambam_sbox_sched.sv
// rambam_sbox_sched: round sequencer that time-multiplexes the AES state and
// key-schedule bytes through N_SBOX pipelined masked S-boxes.
`timescale 1ns/1ps
module rambam_sbox_sched #(
  parameter int N_SBOX   = 1,
  parameter int SBOX_LAT = 7,
  parameter int ROUNDS   = 10,
  localparam int RB      = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          load_en,
  output logic          issue_vld,
  output logic          issue_ks,
  output logic [3:0]    issue_byte,
  output logic          wb_vld,
  output logic          wb_ks,
  output logic [3:0]    wb_byte,
  output logic          lin_en,
  output logic          mix_en,
  output logic [RB-1:0] round
);

  localparam int K = (N_SBOX >= 4) ? 1 : 4 / N_SBOX;
  localparam int S = 16 / N_SBOX;
  localparam logic [3:0] K_LAST = 4'(K - 1);
  localparam logic [3:0] S_LAST = 4'(S - 1);
  localparam logic [RB-1:0] ROUND_LAST = RB'(ROUNDS);
  localparam logic [SBOX_LAT-1:0] REST_MASK = {SBOX_LAT{1'b1}} >> 1;

  typedef enum logic [2:0] {IDLE, LOAD, KS, SB, DRAIN, LIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [RB-1:0]       round_q, round_d;
  logic [SBOX_LAT-1:0] dlVld_q;
  logic [SBOX_LAT-1:0] dlKs_q;
  logic [3:0]          dlByte_q [SBOX_LAT];

  logic                issueRaw;
  logic                issueKsRaw;
  logic [3:0]          issueByteRaw;
  logic                lastWb;

  always_comb begin
    issueRaw     = 1'b0;
    issueKsRaw   = 1'b0;
    issueByteRaw = 4'd0;
    case (state_q)
      KS: begin
        issueRaw     = 1'b1;
        issueKsRaw   = 1'b1;
        issueByteRaw = 4'(12 + int'(cnt_q) * N_SBOX);
      end
      SB: begin
        issueRaw     = 1'b1;
        issueByteRaw = 4'(int'(cnt_q) * N_SBOX);
      end
      default: ;
    endcase
  end

  // The final group is returning when only the tail stage of the delay line holds a result.
  assign lastWb = dlVld_q[SBOX_LAT-1] && ((dlVld_q & REST_MASK) == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        state_d = KS;
        cnt_d   = '0;
        round_d = RB'(1);
      end
      KS: begin
        if (cnt_q == K_LAST) begin
          state_d = SB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SB: begin
        if (cnt_q == S_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DRAIN: if (lastWb) state_d = LIN;
      LIN: begin
        if (round_q != ROUND_LAST) begin
          round_d = round_q + RB'(1);
          state_d = KS;
        end else begin
          round_d = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      round_q  <= '0;
      dlVld_q  <= '0;
      dlKs_q   <= '0;
      for (int i = 0; i < SBOX_LAT; i++) dlByte_q[i] <= '0;
    end else if (!hold) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      round_q     <= round_d;
      dlVld_q[0]  <= issueRaw;
      dlKs_q[0]   <= issueKsRaw;
      dlByte_q[0] <= issueByteRaw;
      for (int i = SBOX_LAT - 1; i > 0; i--) begin
        dlVld_q[i]  <= dlVld_q[i-1];
        dlKs_q[i]   <= dlKs_q[i-1];
        dlByte_q[i] <= dlByte_q[i-1];
      end
    end
  end

  // Strobes drop during hold; levels and indices stay visible.
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE) && !hold;
  assign load_en    = (state_q == LOAD) && !hold;
  assign issue_vld  = issueRaw && !hold;
  assign issue_ks   = issueKsRaw;
  assign issue_byte = issueByteRaw;
  assign wb_vld     = dlVld_q[SBOX_LAT-1] && !hold;
  assign wb_ks      = dlKs_q[SBOX_LAT-1];
  assign wb_byte    = dlByte_q[SBOX_LAT-1];
  assign lin_en     = (state_q == LIN) && !hold;
  assign mix_en     = lin_en && (round_q != ROUND_LAST);
  assign round      = round_q;

endmodule
